sd_wb_master_arbiter: RTL and testbench
=======================================

// Module: sd_wb_master_arbiter
// PURPOSE
//  Shares the single Wishbone master port between the TX FIFO filler (memory reads) and the RX FIFO
//  emptier (memory writes) of the SD DMA. Round-robin grant, held for a whole cyc_o tenure.
//  Optional bus watchdog aborts a stalled cycle. Sits between the filler/emptier masters and the system bus.
// PARAMETERS
//  WDT_CYCLES  1024  cycles a granted cycle may wait for ack before abort (watchdog build only)
//  WDT_W       11    watchdog counter width; must hold WDT_CYCLES
// PORTS
//  clk         in   1   system clock, single clock domain
//  rst         in   1   asynchronous, active-high reset
//  tx_adr_i/tx_we_i/tx_cyc_i/tx_stb_i  in  32/1/1/1   TX filler master request
//  tx_cti_i/tx_bte_i                   in  3/2        TX burst type
//  tx_dat_o    out  32  read data to TX filler
//  tx_ack_o    out  1   ack to TX filler
//  tx_err_o    out  1   watchdog abort to TX filler
//  rx_adr_i/rx_we_i/rx_cyc_i/rx_stb_i  in  32/1/1/1   RX emptier master request
//  rx_cti_i/rx_bte_i                   in  3/2        RX burst type
//  rx_dat_i    in   32  write data from RX emptier
//  rx_ack_o    out  1   ack to RX emptier
//  rx_err_o    out  1   watchdog abort to RX emptier
//  m_wb_adr_o/m_wb_dat_o  out  32/32  shared bus address / write data
//  m_wb_we_o/m_wb_cyc_o/m_wb_stb_o     out  1   shared bus control
//  m_wb_cti_o/m_wb_bte_o  out  3/2    shared bus burst type
//  m_wb_dat_i  in   32  shared bus read data
//  m_wb_ack_i  in   1   shared bus ack
//  grant_o     out  2   current owner: 00 none, 01 TX, 10 RX (status)
// BEHAVIOUR
//  - Reset (async): state IDLE, grant_o=00, rr_last=RX (TX wins first tie), all bus outputs 0, all acks/errs 0.
//  - States: IDLE, OWN_TX, OWN_RX, ABORT. Registered state; bus outputs are a combinational mux of owner inputs.
//  - IDLE: m_wb_cyc_o/stb_o=0. Request = <x>_cyc_i. One requester -> grant next cycle. Both -> grant the one
//    not equal to rr_last. Grant updates rr_last. Request seen at cycle N drives bus at cycle N+1.
//  - OWN_x: m_wb_* = x inputs; m_wb_dat_o = rx_dat_i only in OWN_RX, else 0. m_wb_ack_i routed to x_ack_o only;
//    other ack 0. tx_dat_o = m_wb_dat_i always (qualified by tx_ack_o).
//  - Grant held while x_cyc_i=1, across multiple stb/ack beats and bursts. x_cyc_i=0 -> IDLE next cycle;
//    forced one idle cycle between owners (no back-to-back owner switch).
//  - Owner dropping cyc in its first granted cycle: legal, returns to IDLE, rr_last still updated.
//  - Ack arriving in IDLE or ABORT: discarded, no x_ack_o.
//  - Non-owner requests held pending, never lost; no request dropping or queuing beyond cyc level.
//  - Reset mid-cycle: bus outputs drop to 0 immediately (async); owner sees no ack.
// CONFIGURATION
//  SD_ARB_WDT_EN defined: counter clears on grant and on every m_wb_ack_i; increments each OWN_x cycle
//   with stb and no ack. Reaching WDT_CYCLES -> state ABORT: m_wb_cyc_o/stb_o=0, x_err_o=1 one cycle;
//   ABORT holds until x_cyc_i=0, then IDLE. Ack at the terminal count cycle wins (no abort).
//  SD_ARB_WDT_EN undefined: no counter logic, ABORT unreachable, tx_err_o=rx_err_o=0 constant;
//   WDT_CYCLES/WDT_W ignored.
// STRUCTURE
//  - sd_defines.v: grant encodings (ARB_NONE/ARB_TX/ARB_RX), state encodings, default WDT_CYCLES.
//  - One sub-module sd_wb_arb_wdt (counter + expiry compare), instanced only under SD_ARB_WDT_EN.
//  - Top holds FSM, round-robin pointer and output mux.
// TESTING
//  1 Reset release, tx_cyc_i=1 only -> grant_o=01 next cycle, m_wb_adr_o=tx_adr_i, ack relayed to tx_ack_o only.
//  2 tx_cyc_i & rx_cyc_i both rise same cycle after reset -> TX first; TX drops cyc -> 1 idle cycle -> RX granted.
//  3 Both requesting continuously, 4 tenures -> grant order TX,RX,TX,RX; rx_dat_i=32'hA5A5_5A5A seen on m_wb_dat_o.
//  4 TX 4-beat burst (cti=010..111) while rx_cyc_i=1 -> grant stays TX all 4 acks, rx_ack_o stays 0.
//  5 WDT build, WDT_CYCLES=8, slave never acks -> cyc_o drops after 8 stalled cycles, tx_err_o pulses 1 cycle.
//  6 rst asserted mid RX write -> m_wb_cyc_o/stb_o=0 same cycle, grant_o=00; after release TX wins tie.

Source files
------------

// File: rtl/sd_wb_master_arbiter_pkg.sv
// Shared encodings for the SD DMA Wishbone master arbiter: grant codes, FSM states, watchdog defaults.
package sd_wb_master_arbiter_pkg;

  localparam logic [1:0] ARB_NONE = 2'b00;
  localparam logic [1:0] ARB_TX   = 2'b01;
  localparam logic [1:0] ARB_RX   = 2'b10;

  localparam int WDT_CYCLES_DEF = 1024;
  localparam int WDT_W_DEF      = 11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWN_TX = 2'd1,
    ST_OWN_RX = 2'd2,
    ST_ABORT  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/sd_wb_arb_wdt.sv
// Bus stall watchdog: counts stalled strobe cycles, flags expiry on the last allowed stall cycle.
// Zero-latency expire flag; an ack in the same cycle suppresses expiry.
module sd_wb_arb_wdt #(
  parameter int WDT_CYCLES = 1024,
  parameter int WDT_W      = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  logic [WDT_W-1:0] cnt;

  // clr covers both the grant (not owning) and every ack
  assign expire = inc && !clr && (cnt == WDT_W'(WDT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sd_wb_master_arbiter.sv
// Round-robin Wishbone arbiter for SD DMA TX filler / RX emptier; grant 1 cycle after cyc, held per tenure.
// Bus mux is combinational, owners stall via ack; define SD_ARB_WDT_EN for the stall watchdog abort.
module sd_wb_master_arbiter
  import sd_wb_master_arbiter_pkg::*;
#(
  parameter int WDT_CYCLES = WDT_CYCLES_DEF,
  parameter int WDT_W      = WDT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] tx_adr_i,
  input  logic        tx_we_i,
  input  logic        tx_cyc_i,
  input  logic        tx_stb_i,
  input  logic [2:0]  tx_cti_i,
  input  logic [1:0]  tx_bte_i,
  output logic [31:0] tx_dat_o,
  output logic        tx_ack_o,
  output logic        tx_err_o,
  input  logic [31:0] rx_adr_i,
  input  logic        rx_we_i,
  input  logic        rx_cyc_i,
  input  logic        rx_stb_i,
  input  logic [2:0]  rx_cti_i,
  input  logic [1:0]  rx_bte_i,
  input  logic [31:0] rx_dat_i,
  output logic        rx_ack_o,
  output logic        rx_err_o,
  output logic [31:0] m_wb_adr_o,
  output logic [31:0] m_wb_dat_o,
  output logic        m_wb_we_o,
  output logic        m_wb_cyc_o,
  output logic        m_wb_stb_o,
  output logic [2:0]  m_wb_cti_o,
  output logic [1:0]  m_wb_bte_o,
  input  logic [31:0] m_wb_dat_i,
  input  logic        m_wb_ack_i,
  output logic [1:0]  grant_o
);

  arb_state_t state;
  logic [1:0] rr_last;
  logic       wdt_expire;
  logic       owning;

  assign owning   = (state == ST_OWN_TX) || (state == ST_OWN_RX);
  assign tx_dat_o = m_wb_dat_i;

  // Mux decodes the registered state so an async reset drops the bus at once
  always_comb begin
    m_wb_adr_o = '0;
    m_wb_dat_o = '0;
    m_wb_we_o  = 1'b0;
    m_wb_cyc_o = 1'b0;
    m_wb_stb_o = 1'b0;
    m_wb_cti_o = '0;
    m_wb_bte_o = '0;
    tx_ack_o   = 1'b0;
    rx_ack_o   = 1'b0;
    case (state)
      ST_OWN_TX: begin
        m_wb_adr_o = tx_adr_i;
        m_wb_we_o  = tx_we_i;
        m_wb_cyc_o = tx_cyc_i;
        m_wb_stb_o = tx_stb_i;
        m_wb_cti_o = tx_cti_i;
        m_wb_bte_o = tx_bte_i;
        tx_ack_o   = m_wb_ack_i;
      end
      ST_OWN_RX: begin
        m_wb_adr_o = rx_adr_i;
        m_wb_dat_o = rx_dat_i;
        m_wb_we_o  = rx_we_i;
        m_wb_cyc_o = rx_cyc_i;
        m_wb_stb_o = rx_stb_i;
        m_wb_cti_o = rx_cti_i;
        m_wb_bte_o = rx_bte_i;
        rx_ack_o   = m_wb_ack_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      grant_o <= ARB_NONE;
      rr_last <= ARB_RX;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tx_cyc_i && (!rx_cyc_i || rr_last == ARB_RX)) begin
            state   <= ST_OWN_TX;
            grant_o <= ARB_TX;
            rr_last <= ARB_TX;
          end else if (rx_cyc_i) begin
            state   <= ST_OWN_RX;
            grant_o <= ARB_RX;
            rr_last <= ARB_RX;
          end
        end
        ST_OWN_TX: begin
          if (!tx_cyc_i) begin
            state   <= ST_IDLE;
            grant_o <= ARB_NONE;
          end else if (wdt_expire) begin
            state <= ST_ABORT;
          end
        end
        ST_OWN_RX: begin
          if (!rx_cyc_i) begin
            state   <= ST_IDLE;
            grant_o <= ARB_NONE;
          end else if (wdt_expire) begin
            state <= ST_ABORT;
          end
        end
        ST_ABORT: begin
          // grant_o still names the aborted owner; wait for it to release cyc
          if ((grant_o == ARB_TX && !tx_cyc_i) || (grant_o == ARB_RX && !rx_cyc_i)) begin
            state   <= ST_IDLE;
            grant_o <= ARB_NONE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          grant_o <= ARB_NONE;
        end
      endcase
    end
  end

`ifdef SD_ARB_WDT_EN
  logic tx_err_q;
  logic rx_err_q;

  sd_wb_arb_wdt #(
    .WDT_CYCLES (WDT_CYCLES),
    .WDT_W      (WDT_W)
  ) u_wdt (
    .clk    (clk),
    .rst    (rst),
    .clr    (!owning || m_wb_ack_i),
    .inc    (owning && m_wb_stb_o),
    .expire (wdt_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_err_q <= 1'b0;
      rx_err_q <= 1'b0;
    end else begin
      tx_err_q <= (state == ST_OWN_TX) && tx_cyc_i && wdt_expire;
      rx_err_q <= (state == ST_OWN_RX) && rx_cyc_i && wdt_expire;
    end
  end

  assign tx_err_o = tx_err_q;
  assign rx_err_o = rx_err_q;
`else
  logic unused_wdt_cfg;

  assign unused_wdt_cfg = owning ^ (WDT_CYCLES > 0) ^ (WDT_W > 0);
  assign wdt_expire     = 1'b0;
  assign tx_err_o       = 1'b0;
  assign rx_err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_sd_wb_master_arbiter.sv
// Bench for sd_wb_master_arbiter: vector table, directed corner sequences, randomized run against a model.
module tb_sd_wb_master_arbiter;

  localparam int WDT_N = 8;
  localparam logic [31:0] TA = 32'h1000_0040;
  localparam logic [31:0] RA = 32'h2000_0080;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] tx_adr_i, rx_adr_i, rx_dat_i, m_wb_dat_i;
  logic        tx_we_i, tx_cyc_i, tx_stb_i, rx_we_i, rx_cyc_i, rx_stb_i, m_wb_ack_i;
  logic [2:0]  tx_cti_i, rx_cti_i;
  logic [1:0]  tx_bte_i, rx_bte_i;
  logic [31:0] tx_dat_o, m_wb_adr_o, m_wb_dat_o;
  logic        tx_ack_o, tx_err_o, rx_ack_o, rx_err_o;
  logic        m_wb_we_o, m_wb_cyc_o, m_wb_stb_o;
  logic [2:0]  m_wb_cti_o;
  logic [1:0]  m_wb_bte_o, grant_o;

  sd_wb_master_arbiter #(.WDT_CYCLES(WDT_N), .WDT_W(11)) dut (
    .clk(clk), .rst(rst),
    .tx_adr_i(tx_adr_i), .tx_we_i(tx_we_i), .tx_cyc_i(tx_cyc_i), .tx_stb_i(tx_stb_i),
    .tx_cti_i(tx_cti_i), .tx_bte_i(tx_bte_i), .tx_dat_o(tx_dat_o), .tx_ack_o(tx_ack_o),
    .tx_err_o(tx_err_o),
    .rx_adr_i(rx_adr_i), .rx_we_i(rx_we_i), .rx_cyc_i(rx_cyc_i), .rx_stb_i(rx_stb_i),
    .rx_cti_i(rx_cti_i), .rx_bte_i(rx_bte_i), .rx_dat_i(rx_dat_i), .rx_ack_o(rx_ack_o),
    .rx_err_o(rx_err_o),
    .m_wb_adr_o(m_wb_adr_o), .m_wb_dat_o(m_wb_dat_o), .m_wb_we_o(m_wb_we_o),
    .m_wb_cyc_o(m_wb_cyc_o), .m_wb_stb_o(m_wb_stb_o), .m_wb_cti_o(m_wb_cti_o),
    .m_wb_bte_o(m_wb_bte_o), .m_wb_dat_i(m_wb_dat_i), .m_wb_ack_i(m_wb_ack_i),
    .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    tx_adr_i = TA; rx_adr_i = RA; rx_dat_i = 32'h0; m_wb_dat_i = 32'h0;
    tx_we_i = 1'b0; rx_we_i = 1'b1; tx_cyc_i = 1'b0; tx_stb_i = 1'b0;
    rx_cyc_i = 1'b0; rx_stb_i = 1'b0; m_wb_ack_i = 1'b0;
    tx_cti_i = 3'b000; rx_cti_i = 3'b000; tx_bte_i = 2'b00; rx_bte_i = 2'b00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        tx_cyc;
    logic        rx_cyc;
    logic        ack;
    logic [1:0]  grant;
    logic        cyc;
    logic        tx_ack;
    logic        rx_ack;
    logic [31:0] adr;
  } vec_t;

  vec_t tbl[12];

  // random-phase reference model state
  int owner, last, cnt, own_cyc, own_stb;
  bit abort_m, etx, erx;
  logic [1:0] eg;

  initial begin
    // inputs: tx_cyc rx_cyc ack | expected: grant cyc tx_ack rx_ack adr
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, TA};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, TA};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, TA};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, RA};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, RA};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, TA};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, TA};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, RA};

    do_reset();
    chk("reset_grant", grant_o, 2'b00);
    chk("reset_cyc", m_wb_cyc_o, 1'b0);
    chk("reset_stb", m_wb_stb_o, 1'b0);
    chk("reset_adr", m_wb_adr_o, 32'h0);
    chk("reset_acks", {tx_ack_o, rx_ack_o, tx_err_o, rx_err_o}, 4'b0000);

    for (int i = 0; i < 12; i++) begin
      tx_cyc_i = tbl[i].tx_cyc; tx_stb_i = tbl[i].tx_cyc;
      rx_cyc_i = tbl[i].rx_cyc; rx_stb_i = tbl[i].rx_cyc;
      m_wb_ack_i = tbl[i].ack;
      #1;
      chk($sformatf("vec%0d_grant", i), grant_o, tbl[i].grant);
      chk($sformatf("vec%0d_cyc", i), m_wb_cyc_o, tbl[i].cyc);
      chk($sformatf("vec%0d_tx_ack", i), tx_ack_o, tbl[i].tx_ack);
      chk($sformatf("vec%0d_rx_ack", i), rx_ack_o, tbl[i].rx_ack);
      chk($sformatf("vec%0d_adr", i), m_wb_adr_o, tbl[i].adr);
      tick();
    end

    // Alternating grant order with continuous requests, one idle cycle per handover
    do_reset();
    rx_dat_i = 32'hA5A5_5A5A;
    tx_cyc_i = 1'b1; tx_stb_i = 1'b1; rx_cyc_i = 1'b1; rx_stb_i = 1'b1; m_wb_ack_i = 1'b1;
    for (int t = 0; t < 4; t++) begin
      int w;
      w = 0;
      while (grant_o == 2'b00 && w < 5) begin
        tick();
        w++;
      end
      chk($sformatf("rr_order%0d", t), grant_o, (t % 2 == 0) ? 2'b01 : 2'b10);
      if (t % 2 == 1) chk("rx_wdata", m_wb_dat_o, 32'hA5A5_5A5A);
      else chk("tx_wdata_zero", m_wb_dat_o, 32'h0);
      if (t % 2 == 0) tx_cyc_i = 1'b0; else rx_cyc_i = 1'b0;
      #1;
      chk("drop_cyc_o", m_wb_cyc_o, 1'b0);
      tick();
      chk("gap_idle", grant_o, 2'b00);
      tx_cyc_i = 1'b1; rx_cyc_i = 1'b1;
    end

    // TX 4-beat burst while RX waits
    do_reset();
    tx_cyc_i = 1'b1; tx_stb_i = 1'b1; rx_cyc_i = 1'b1; rx_stb_i = 1'b1;
    tick();
    for (int b = 0; b < 4; b++) begin
      tx_cti_i = (b == 3) ? 3'b111 : 3'b010;
      m_wb_ack_i = 1'b1;
      m_wb_dat_i = 32'hD000_0000 + b;
      #1;
      chk($sformatf("burst%0d_grant", b), grant_o, 2'b01);
      chk($sformatf("burst%0d_cti", b), m_wb_cti_o, tx_cti_i);
      chk($sformatf("burst%0d_tx_ack", b), tx_ack_o, 1'b1);
      chk($sformatf("burst%0d_rx_ack", b), rx_ack_o, 1'b0);
      chk($sformatf("burst%0d_rdata", b), tx_dat_o, 32'hD000_0000 + b);
      tick();
    end

    // Async reset in the middle of an RX write
    do_reset();
    rx_cyc_i = 1'b1; rx_stb_i = 1'b1;
    tick();
    m_wb_ack_i = 1'b1;
    #1;
    chk("pre_rst_cyc", m_wb_cyc_o, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_cyc", m_wb_cyc_o, 1'b0);
    chk("mid_rst_stb", m_wb_stb_o, 1'b0);
    chk("mid_rst_grant", grant_o, 2'b00);
    chk("mid_rst_rx_ack", rx_ack_o, 1'b0);
    tx_cyc_i = 1'b1; tx_stb_i = 1'b1; m_wb_ack_i = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_idle", grant_o, 2'b00);
    tick();
    chk("post_rst_tie_tx", grant_o, 2'b01);

`ifdef SD_ARB_WDT_EN
    // Slave never acks: abort after WDT_N stalled cycles
    do_reset();
    tx_cyc_i = 1'b1; tx_stb_i = 1'b1;
    tick();
    for (int k = 0; k < WDT_N; k++) begin
      chk($sformatf("wdt_stall%0d_cyc", k), m_wb_cyc_o, 1'b1);
      chk($sformatf("wdt_stall%0d_err", k), tx_err_o, 1'b0);
      tick();
    end
    chk("wdt_abort_cyc", m_wb_cyc_o, 1'b0);
    chk("wdt_abort_stb", m_wb_stb_o, 1'b0);
    chk("wdt_abort_tx_err", tx_err_o, 1'b1);
    chk("wdt_abort_rx_err", rx_err_o, 1'b0);
    tick();
    chk("wdt_err_pulse_end", tx_err_o, 1'b0);
    chk("wdt_abort_hold", m_wb_cyc_o, 1'b0);
    tx_cyc_i = 1'b0;
    tick();
    chk("wdt_back_idle", grant_o, 2'b00);

    // Ack on the terminal stall cycle wins over the abort
    do_reset();
    tx_cyc_i = 1'b1; tx_stb_i = 1'b1;
    tick();
    for (int k = 0; k < WDT_N - 1; k++) tick();
    m_wb_ack_i = 1'b1;
    tick();
    m_wb_ack_i = 1'b0;
    chk("wdt_ack_wins_cyc", m_wb_cyc_o, 1'b1);
    chk("wdt_ack_wins_err", tx_err_o, 1'b0);
`endif

    // Randomized traffic against the reference model
    do_reset();
    owner = 0; last = 2; cnt = 0; abort_m = 1'b0; etx = 1'b0; erx = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 4) == 0) tx_cyc_i = ~tx_cyc_i;
      if ($urandom_range(0, 4) == 0) rx_cyc_i = ~rx_cyc_i;
      tx_stb_i = tx_cyc_i & ($urandom_range(0, 3) != 0);
      rx_stb_i = rx_cyc_i & ($urandom_range(0, 3) != 0);
      tx_adr_i = $urandom; rx_adr_i = $urandom; rx_dat_i = $urandom; m_wb_dat_i = $urandom;
      tx_we_i = 1'($urandom_range(0, 1)); rx_we_i = 1'($urandom_range(0, 1));
      tx_cti_i = 3'($urandom_range(0, 7)); rx_cti_i = 3'($urandom_range(0, 7));
      tx_bte_i = 2'($urandom_range(0, 3)); rx_bte_i = 2'($urandom_range(0, 3));
      m_wb_ack_i = ($urandom_range(0, 2) != 0);
      #1;
      own_cyc = (owner == 1) ? int'(tx_cyc_i) : (owner == 2) ? int'(rx_cyc_i) : 0;
      own_stb = (owner == 1) ? int'(tx_stb_i) : (owner == 2) ? int'(rx_stb_i) : 0;
      eg = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;
      if (!abort_m) chk("rnd_grant", grant_o, eg);
      if (owner != 0 && !abort_m) begin
        chk("rnd_cyc", m_wb_cyc_o, own_cyc);
        chk("rnd_stb", m_wb_stb_o, own_stb);
        chk("rnd_adr", m_wb_adr_o, (owner == 1) ? tx_adr_i : rx_adr_i);
        chk("rnd_we", m_wb_we_o, (owner == 1) ? tx_we_i : rx_we_i);
        chk("rnd_cti_bte", {m_wb_cti_o, m_wb_bte_o},
            (owner == 1) ? {tx_cti_i, tx_bte_i} : {rx_cti_i, rx_bte_i});
        chk("rnd_wdat", m_wb_dat_o, (owner == 2) ? rx_dat_i : 32'h0);
        chk("rnd_acks", {tx_ack_o, rx_ack_o}, {owner == 1 && m_wb_ack_i, owner == 2 && m_wb_ack_i});
      end else begin
        chk("rnd_idle_bus", {m_wb_cyc_o, m_wb_stb_o, m_wb_adr_o}, 34'h0);
        chk("rnd_idle_acks", {tx_ack_o, rx_ack_o}, 2'b00);
      end
      chk("rnd_rdata", tx_dat_o, m_wb_dat_i);
      chk("rnd_errs", {tx_err_o, rx_err_o}, {etx, erx});

      etx = 1'b0; erx = 1'b0;
      if (owner == 0) begin
        if (tx_cyc_i && rx_cyc_i) owner = (last == 1) ? 2 : 1;
        else if (tx_cyc_i) owner = 1;
        else if (rx_cyc_i) owner = 2;
        if (owner != 0) last = owner;
        cnt = 0;
      end else if (abort_m) begin
        if (own_cyc == 0) begin owner = 0; abort_m = 1'b0; end
      end else if (own_cyc == 0) begin
        owner = 0;
      end else if (m_wb_ack_i) begin
        cnt = 0;
      end else if (own_stb != 0) begin
        cnt++;
`ifdef SD_ARB_WDT_EN
        if (cnt == WDT_N) begin
          abort_m = 1'b1;
          if (owner == 1) etx = 1'b1; else erx = 1'b1;
        end
`endif
      end
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
